multiword_add_seq: RTL and testbench
====================================

MULTIWORD_ADD_SEQ -- requirements
Module: multiword_add_seq

Interface
REQ-001 SHALL have parameter NWORDS, default 4: number of 32-bit words per operand (legal 2..8).
REQ-002 SHALL have port clk  input  1: single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1: synchronous, active-high reset.
REQ-004 SHALL have ports in_valid input 1, in_ready output 1: operand handshake.
REQ-005 SHALL have ports op_a, op_b  input  32*NWORDS: wide operands, word 0 = bits [31:0].
REQ-006 SHALL have port op_cin  input  1: carry-in of the wide add.
REQ-007 SHALL have ports add_a, add_b output 32, add_cin output 1: word operands and carry to the external 32-bit adder.
REQ-008 SHALL have ports add_sum input 32, add_cout input 1: combinational result returned by the external 32-bit adder in the same cycle.
REQ-009 SHALL have ports out_valid output 1, out_ready input 1: result handshake.
REQ-010 SHALL have ports out_sum output 32*NWORDS, out_cout output 1: wide sum and final carry.
REQ-011 SHALL have port busy  output 1: high in every state except IDLE.

Function
REQ-012 SHALL implement FSM states IDLE, RUN, DONE.
REQ-013 IDLE: in_ready=1; on in_valid&&in_ready SHALL register op_a, op_b, op_cin into internal state, clear word index to 0, set carry register to op_cin, go to RUN.
REQ-014 RUN: SHALL drive add_a/add_b with word[idx] of the registered operands and add_cin with the carry register; in_ready=0.
REQ-015 RUN: each cycle SHALL store add_sum into result word idx, load add_cout into the carry register, increment idx.
REQ-016 RUN with idx==NWORDS-1: SHALL go to DONE after storing the word; out_cout SHALL take that cycle's add_cout.
REQ-017 Outside RUN, add_a, add_b, add_cin SHALL be driven 0.
REQ-018 DONE: out_valid=1, in_ready=0; on out_ready SHALL go to IDLE; out_valid SHALL fall in the following cycle.
REQ-019 While out_valid&&!out_ready, out_sum, out_cout (and out_ovf if present) SHALL be held stable.
REQ-020 Latency: accept at edge E; out_valid SHALL be high in the cycle following edge E+NWORDS; throughput one operation per NWORDS+2 cycles minimum.
REQ-021 in_valid asserted in RUN or DONE SHALL be ignored; no operand capture and no state change.
REQ-022 Arithmetic SHALL be unsigned modulo 2^(32*NWORDS); {out_cout,out_sum} = op_a+op_b+op_cin exactly.
REQ-023 out_sum/out_cout SHALL retain the last result after return to IDLE until the next word store overwrites them.

Reset
REQ-024 rst=1 at a clock edge SHALL force IDLE from any state, including mid-RUN and DONE, abandoning the operation.
REQ-025 After reset: in_ready=1, out_valid=0, busy=0, out_sum=0, out_cout=0, carry register=0, idx=0, out_ovf=0 if present.
REQ-026 rst SHALL take priority over in_valid and out_ready in the same cycle.

Configuration
REQ-027 Macro MWADD_OVF_EN defined: SHALL add port out_ovf output 1 = two's-complement overflow of the wide add (MSB of op_a equals MSB of op_b and differs from MSB of out_sum), registered and updated with the final word.
REQ-028 Macro MWADD_OVF_EN undefined: out_ovf port and its logic SHALL be absent; all other behaviour is identical.

Verification
REQ-029 NWORDS=4, a=128'h0000_0000_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, b=1, cin=0 -> out_sum=128'h0000_0001_0000_0000_0000_0000_0000_0000, out_cout=0, out_valid in cycle after edge E+4.
REQ-030 a=all ones, b=0, cin=1 -> out_sum=0, out_cout=1, add_cin sequence 1,1,1,1; out_ovf=0 when MWADD_OVF_EN.
REQ-031 a=128'h7FFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, b=1, cin=0 -> out_sum=128'h8000_0000_0000_0000_0000_0000_0000_0000, out_cout=0, out_ovf=1 when MWADD_OVF_EN.
REQ-032 out_ready held 0 for 3 cycles in DONE with in_valid=1 -> out_valid and out_sum stable, in_ready=0, no capture; out_ready=1 -> IDLE next cycle.
REQ-033 rst pulsed during second RUN cycle -> next cycle in_ready=1, busy=0, out_valid=0, out_sum=0; following op a=5, b=7, cin=0 -> out_sum=12, out_cout=0.

Source files
------------

// File: rtl/multiword_add_seq.sv
// Multi-word adder sequencer: adds NWORDS 32-bit words through one external adder.
// Define MWADD_OVF_EN to add the registered signed-overflow output out_ovf.
module multiword_add_seq #(
  parameter int NWORDS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [32*NWORDS-1:0]  op_a,
  input  logic [32*NWORDS-1:0]  op_b,
  input  logic                  op_cin,
  output logic [31:0]           add_a,
  output logic [31:0]           add_b,
  output logic                  add_cin,
  input  logic [31:0]           add_sum,
  input  logic                  add_cout,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [32*NWORDS-1:0]  out_sum,
  output logic                  out_cout,
`ifdef MWADD_OVF_EN
  output logic                  out_ovf,
`endif
  output logic                  busy
);

  localparam int IW = $clog2(NWORDS);
  localparam int MSB = 32*NWORDS-1;
  localparam logic [IW-1:0] LAST = IW'(NWORDS-1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic [32*NWORDS-1:0] a_q, b_q, sum_q;
  logic [IW-1:0]        idx_q;
  logic                 carry_q;
  logic                 cout_q;
  logic                 last;

  assign last = (idx_q == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    add_a     = '0;
    add_b     = '0;
    add_cin   = 1'b0;
    unique case (1'b1)
      (state_q == IDLE): begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_d = RUN;
      end
      (state_q == RUN): begin
        add_a   = a_q[idx_q*32 +: 32];
        add_b   = b_q[idx_q*32 +: 32];
        add_cin = carry_q;
        if (last) state_d = DONE;
      end
      (state_q == DONE): begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Result words are written in place, so the previous result persists until overwritten.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
    end else if (state_q == IDLE && in_valid) begin
      a_q     <= op_a;
      b_q     <= op_b;
      carry_q <= op_cin;
      idx_q   <= '0;
    end else if (state_q == RUN) begin
      sum_q[idx_q*32 +: 32] <= add_sum;
      carry_q <= add_cout;
      idx_q   <= idx_q + 1'b1;
      if (last) cout_q <= add_cout;
    end
  end

  assign out_sum  = sum_q;
  assign out_cout = cout_q;

`ifdef MWADD_OVF_EN
  logic ovf_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (state_q == RUN && last) begin
      ovf_q <= (a_q[MSB] == b_q[MSB]) && (add_sum[31] != a_q[MSB]);
    end
  end

  assign out_ovf = ovf_q;
`endif

endmodule

// File: tb/tb_multiword_add_seq.sv
// Directed bench for multiword_add_seq with a behavioural 32-bit adder.
// Build with MWADD_OVF_EN defined to also check out_ovf.
module tb_multiword_add_seq;

  localparam int NW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [127:0]  op_a, op_b;
  logic          op_cin;
  logic [31:0]   add_a, add_b, add_sum;
  logic          add_cin, add_cout;
  logic          out_valid, out_ready;
  logic [127:0]  out_sum;
  logic          out_cout;
  logic          busy;
`ifdef MWADD_OVF_EN
  logic          out_ovf;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {32'd0, add_cin};

  multiword_add_seq #(.NWORDS(NW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .op_cin    (op_cin),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_cin   (add_cin),
    .add_sum   (add_sum),
    .add_cout  (add_cout),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
`ifdef MWADD_OVF_EN
    .out_ovf   (out_ovf),
`endif
    .busy      (busy)
  );

  task automatic chk(input string tag, input logic [127:0] got,
                     input logic [127:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [127:0] a, input logic [127:0] b,
                        input logic cin, input logic [127:0] es,
                        input logic ec, input logic eo,
                        input logic [3:0] ecins, input int hold);
    logic [3:0] cins;
    logic [127:0] garbage;
    cins = '0;
    garbage = ~a;
    op_a = a;
    op_b = b;
    op_cin = cin;
    in_valid = 1'b1;
    chk("accept_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < NW; k++) begin
      chk("run_busy", busy, 1);
      chk("run_in_ready", in_ready, 0);
      chk("run_out_valid", out_valid, 0);
      chk("run_add_a", add_a, a[k*32 +: 32]);
      cins[k] = add_cin;
      tick();
    end
    chk("cin_seq", cins, ecins);
    chk("lat_out_valid", out_valid, 1);
    chk("sum", out_sum, es);
    chk("cout", out_cout, ec);
    chk("done_add_a_zero", add_a, 0);
`ifdef MWADD_OVF_EN
    chk("ovf", out_ovf, eo);
`else
    if (eo === 1'bx) $display("unreachable");
`endif
    for (int h = 0; h < hold; h++) begin
      op_a = garbage;
      op_b = garbage;
      in_valid = 1'b1;
      tick();
      chk("hold_valid", out_valid, 1);
      chk("hold_in_ready", in_ready, 0);
      chk("hold_sum", out_sum, es);
      chk("hold_cout", out_cout, ec);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("ret_out_valid", out_valid, 0);
    chk("ret_in_ready", in_ready, 1);
    chk("ret_busy", busy, 0);
    chk("retain_sum", out_sum, es);
    chk("retain_cout", out_cout, ec);
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    op_a = '0;
    op_b = '0;
    op_cin = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sum", out_sum, 0);
    chk("rst_cout", out_cout, 0);
    chk("rst_add_cin", add_cin, 0);

    run_op(128'h0000_0000_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 128'd1, 1'b0,
           128'h0000_0001_0000_0000_0000_0000_0000_0000, 1'b0, 1'b0,
           4'b1110, 0);
    run_op({128{1'b1}}, 128'd0, 1'b1, 128'd0, 1'b1, 1'b0, 4'b1111, 0);
    run_op(128'h7FFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 128'd1, 1'b0,
           128'h8000_0000_0000_0000_0000_0000_0000_0000, 1'b0, 1'b1,
           4'b1110, 3);
    run_op(128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321,
           128'hFEDC_BA98_7654_3210_F012_3456_789A_BCDE, 1'b1,
           128'h1111_1111_1111_1101_0000_0000_0000_0000, 1'b1, 1'b0,
           4'b1111, 0);

    op_a = 128'h3;
    op_b = 128'h4;
    op_cin = 1'b0;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    chk("mid_busy", busy, 1);
    chk("mid_sum_w0", out_sum[31:0], 7);
    rst = 1'b1;
    in_valid = 1'b1;
    out_ready = 1'b1;
    tick();
    rst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    chk("mrst_in_ready", in_ready, 1);
    chk("mrst_busy", busy, 0);
    chk("mrst_out_valid", out_valid, 0);
    chk("mrst_sum", out_sum, 0);
    chk("mrst_cout", out_cout, 0);

    run_op(128'd5, 128'd7, 1'b0, 128'd12, 1'b0, 1'b0, 4'b0000, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
